ring_serial_tx: RTL and testbench

//  Serial link transmitter for the token-ring router: the sending end of the S_Data_out link.

---
 rtl/ring_pkg.sv | 21 ++
 rtl/ring_frame_builder.sv | 27 ++
 rtl/ring_serial_tx.sv | 115 +++++++++++
 tb/tb_ring_serial_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// ring_pkg: frame type codes, field widths and type helpers shared by the ring serial TX and RX.
package ring_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 24;
  localparam int TYPE_W = 3;
  localparam int LONG_BITS = 37;
  localparam int SHORT_BITS = 12;
  typedef enum logic [2:0] {
    T_ACK    = 3'b000,
    T_DATA_3 = 3'b001,
    T_DATA_C = 3'b010,
    T_NACK   = 3'b011,
    T_TOKEN  = 3'b111
  } frame_type_e;
  function automatic logic is_long_type(input logic [2:0] t);
    return t == T_DATA_C || t == T_DATA_3;
  endfunction
  function automatic logic is_legal_type(input logic [2:0] t);
    return t inside {T_TOKEN, T_ACK, T_NACK, T_DATA_C, T_DATA_3};
  endfunction
endpackage

// File: rtl/ring_frame_builder.sv
// ring_frame_builder: packs captured fields into a left-justified frame body with even parity and its length.
module ring_frame_builder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 24,
  parameter int BODY_W = 3 + 2 * ADDR_W + DATA_W + 2,
  parameter int CNT_W = 6
) (
  input  logic [2:0]        ftype,
  input  logic [ADDR_W-1:0] dest,
  input  logic [ADDR_W-1:0] src,
  input  logic              encode,
  input  logic [DATA_W-1:0] data,
  output logic [BODY_W-1:0] body,
  output logic [CNT_W-1:0]  len
);
  import ring_pkg::*;
  localparam int SHORT_W = 3 + 2 * ADDR_W + 1;
  logic [BODY_W-2:0] long_f;
  logic [SHORT_W-2:0] short_f;
  logic is_long;
  assign long_f = {ftype, dest, src, encode, data};
  assign short_f = {ftype, dest, src};
  assign is_long = is_long_type(ftype);
  // short bodies sit in the top bits so the shifter always sends from the MSB
  assign body = is_long ? {long_f, ^long_f} : {short_f, ^short_f, {(BODY_W - SHORT_W){1'b0}}};
  assign len = is_long ? CNT_W'(BODY_W) : CNT_W'(SHORT_W);
endmodule

// File: rtl/ring_serial_tx.sv
// ring_serial_tx: token-ring link transmitter, serialises one accepted frame MSB-first onto S_Data_out.
module ring_serial_tx #(
  parameter int GAP_BITS = 2,
  parameter int ADDR_W = ring_pkg::ADDR_W,
  parameter int DATA_W = ring_pkg::DATA_W
) (
  input  logic              Clk_S,
  input  logic              Rst_n,
  input  logic              TX_Valid,
  input  logic [2:0]        TX_Type,
  input  logic [ADDR_W-1:0] TX_Dest,
  input  logic [ADDR_W-1:0] TX_Src,
  input  logic              TX_Encode,
  input  logic [DATA_W-1:0] TX_Data,
  output logic              TX_Ready,
  output logic              TX_Done,
  output logic              TX_Err,
  output logic              S_Data_out
);
  import ring_pkg::*;
  localparam int BODY_W = 3 + 2 * ADDR_W + DATA_W + 2;
  localparam int CNT_W = $clog2(BODY_W + 1);
  localparam int GAP_W = GAP_BITS > 1 ? $clog2(GAP_BITS) : 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  logic [2:0] state;
  logic [BODY_W-1:0] shreg, body;
  logic [CNT_W-1:0] cnt, len;
  logic [GAP_W-1:0] gcnt;
  logic accept;
  assign accept = TX_Valid && TX_Ready;
  ring_frame_builder #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BODY_W(BODY_W),
    .CNT_W (CNT_W)
  ) u_builder (
    .ftype (TX_Type),
    .dest  (TX_Dest),
    .src   (TX_Src),
    .encode(TX_Encode),
    .data  (TX_Data),
    .body  (body),
    .len   (len)
  );
  always_ff @(posedge Clk_S) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      S_Data_out <= 1'b1;
      TX_Ready <= 1'b0;
      TX_Done <= 1'b0;
      TX_Err <= 1'b0;
      shreg <= '0;
      cnt <= '0;
      gcnt <= '0;
    end else begin
      TX_Done <= 1'b0;
      TX_Err <= 1'b0;
      case (state)
        S_IDLE: begin
          S_Data_out <= 1'b1;
          TX_Ready <= 1'b1;
          if (accept && is_legal_type(TX_Type)) begin
            state <= S_START;
            S_Data_out <= 1'b0;
            TX_Ready <= 1'b0;
            shreg <= body;
            cnt <= len - CNT_W'(1);
          end else if (accept) begin
            TX_Err <= 1'b1;
          end
        end
        S_START: begin
          state <= S_SHIFT;
          S_Data_out <= shreg[BODY_W-1];
          shreg <= shreg << 1;
        end
        S_SHIFT: begin
          // terminal count checked before decrement, so cnt never wraps
          if (cnt == '0) begin
            state <= S_STOP;
            S_Data_out <= 1'b1;
            TX_Done <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
            S_Data_out <= shreg[BODY_W-1];
            shreg <= shreg << 1;
          end
        end
        S_STOP: begin
          state <= S_GAP;
          S_Data_out <= 1'b1;
          gcnt <= GAP_W'(GAP_BITS - 1);
        end
        S_GAP: begin
          S_Data_out <= 1'b1;
          if (gcnt == '0) begin
            state <= S_IDLE;
            TX_Ready <= 1'b1;
          end else begin
            gcnt <= gcnt - GAP_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          S_Data_out <= 1'b1;
          TX_Ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ring_serial_tx.sv
// tb_ring_serial_tx: directed vector bench for ring_serial_tx with hand-computed parities and frame timing.
module tb_ring_serial_tx;
  localparam int GAP = 2;
  logic Clk_S = 1'b0;
  logic Rst_n = 1'b0;
  logic TX_Valid = 1'b0;
  logic [2:0] TX_Type = '0;
  logic [3:0] TX_Dest = '0;
  logic [3:0] TX_Src = '0;
  logic TX_Encode = 1'b0;
  logic [23:0] TX_Data = '0;
  logic TX_Ready, TX_Done, TX_Err, S_Data_out;
  int n_vec = 0;
  int n_bad = 0;

  ring_serial_tx #(.GAP_BITS(GAP), .ADDR_W(4), .DATA_W(24)) dut (
    .Clk_S     (Clk_S),
    .Rst_n     (Rst_n),
    .TX_Valid  (TX_Valid),
    .TX_Type   (TX_Type),
    .TX_Dest   (TX_Dest),
    .TX_Src    (TX_Src),
    .TX_Encode (TX_Encode),
    .TX_Data   (TX_Data),
    .TX_Ready  (TX_Ready),
    .TX_Done   (TX_Done),
    .TX_Err    (TX_Err),
    .S_Data_out(S_Data_out)
  );

  always #5 Clk_S = ~Clk_S;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  ty;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic        enc;
    logic [23:0] dat;
    logic        par;
    int          flen;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [38:0] exp_frame(input vec_t v);
    return v.flen == 39 ? {1'b0, v.ty, v.dst, v.src, v.enc, v.dat, v.par, 1'b1}
                        : {1'b0, v.ty, v.dst, v.src, v.par, 1'b1, 25'b0};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk_S);
      if (TX_Ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: TX_Ready got 0 expected 1 within 100 cycles");
    end
  endtask

  task automatic drive(input vec_t v);
    TX_Valid = 1'b1;
    TX_Type = v.ty;
    TX_Dest = v.dst;
    TX_Src = v.src;
    TX_Encode = v.enc;
    TX_Data = v.dat;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [38:0] got;
    logic [63:0] gd, gr, ge, gg;
    int n;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    drive(v);
    @(posedge Clk_S);
    n = v.flen + GAP;
    got = '0; gd = '0; gr = '0; ge = '0; gg = '0;
    for (int j = 0; j <= n; j++) begin
      @(negedge Clk_S);
      if (j == 0) begin
        TX_Valid = 1'b0;
        TX_Type = ~v.ty;
        TX_Dest = ~v.dst;
        TX_Src = ~v.src;
        TX_Encode = ~v.enc;
        TX_Data = ~v.dat;
      end
      if (j < v.flen) got[38-j] = S_Data_out;
      else gg[j-v.flen] = S_Data_out;
      gd[j] = TX_Done;
      gr[j] = TX_Ready;
      ge[j] = TX_Err;
    end
    chk({tag, "_frame"}, 128'(got), 128'(exp_frame(v)));
    chk({tag, "_gap_line"}, 128'(gg), 128'((64'd1 << (GAP + 1)) - 1));
    chk({tag, "_done"}, 128'(gd), 128'(64'd1 << (v.flen - 1)));
    chk({tag, "_ready"}, 128'(gr), 128'(64'd1 << n));
    chk({tag, "_err"}, 128'(ge), 128'(0));
  endtask

  initial begin
    logic [127:0] ln;
    logic [63:0] a, b;
    int idx;
    bit ok;
    //            type    dst    src    enc   data          par   len
    vecs[0] = '{3'b111, 4'h2, 4'h0, 1'b0, 24'h000000, 1'b0, 14};
    vecs[1] = '{3'b000, 4'h5, 4'h3, 1'b0, 24'h000000, 1'b0, 14};
    vecs[2] = '{3'b011, 4'h6, 4'h8, 1'b0, 24'h000000, 1'b1, 14};
    vecs[3] = '{3'b001, 4'h2, 4'h0, 1'b1, 24'h001234, 1'b0, 39};
    vecs[4] = '{3'b010, 4'hF, 4'hA, 1'b0, 24'hFFFFFF, 1'b1, 39};
    vecs[5] = '{3'b001, 4'h0, 4'h1, 1'b0, 24'h800000, 1'b1, 39};
    vecs[6] = '{3'b111, 4'hF, 4'hF, 1'b0, 24'h000000, 1'b1, 14};

    // reset state, then idle after release
    repeat (3) @(negedge Clk_S);
    chk("reset_outputs", 128'({S_Data_out, TX_Ready, TX_Done, TX_Err}), 128'(4'b1000));
    Rst_n = 1'b1;
    a = '0; b = '0;
    for (int j = 0; j < 6; j++) begin
      @(negedge Clk_S);
      a[j] = S_Data_out & TX_Ready;
      b[j] = TX_Done | TX_Err;
    end
    chk("idle_line_ready", 128'(a), 128'(64'h3F));
    chk("idle_no_pulses", 128'(b), 128'(0));

    for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // illegal types pulse TX_Err for one cycle and start nothing
    for (int t = 4; t <= 6; t++) begin
      wait_ready(ok);
      if (ok) begin
        drive(vecs[0]);
        TX_Type = 3'(t);
        @(posedge Clk_S);
        @(negedge Clk_S);
        chk($sformatf("illegal%0d_pulse", t), 128'({TX_Err, S_Data_out, TX_Ready}), 128'(3'b111));
        TX_Valid = 1'b0;
        @(negedge Clk_S);
        chk($sformatf("illegal%0d_after", t), 128'({TX_Err, S_Data_out, TX_Ready, TX_Done}), 128'(4'b0110));
      end
    end

    // TX_Valid held high across two long frames
    wait_ready(ok);
    if (ok) begin
      drive(vecs[3]);
      @(posedge Clk_S);
      ln = '0;
      for (int j = 0; j < 85; j++) begin
        @(negedge Clk_S);
        if (j == 0) drive(vecs[4]);
        if (j == 42) TX_Valid = 1'b0;
        ln[j] = S_Data_out;
      end
      a = '0; b = '0;
      for (int j = 0; j < 39; j++) begin
        a[38-j] = ln[j];
        b[38-j] = ln[42+j];
      end
      idx = -1;
      for (int j = 39; j < 85; j++) if (idx < 0 && ln[j] == 1'b0) idx = j;
      chk("b2b_first_frame", 128'(a), 128'(exp_frame(vecs[3])));
      chk("b2b_second_start", 128'(idx), 128'(42));
      chk("b2b_second_frame", 128'(b), 128'(exp_frame(vecs[4])));
    end

    // reset asserted while body bit 20 of a long frame is on the line
    wait_ready(ok);
    if (ok) begin
      drive(vecs[4]);
      @(posedge Clk_S);
      a = '0;
      for (int j = 0; j <= 20; j++) begin
        @(negedge Clk_S);
        if (j == 0) TX_Valid = 1'b0;
        a[20-j] = S_Data_out;
      end
      chk("rst_mid_prefix", 128'(a), 128'(exp_frame(vecs[4]) >> 18));
      Rst_n = 1'b0;
      @(negedge Clk_S);
      chk("rst_mid_outputs", 128'({S_Data_out, TX_Done, TX_Ready}), 128'(3'b100));
      Rst_n = 1'b1;
      a = '0; b = '0;
      for (int j = 0; j < 45; j++) begin
        @(negedge Clk_S);
        a[j] = S_Data_out;
        b[j] = TX_Done;
      end
      chk("rst_mid_line_idle", 128'(a), 128'((64'd1 << 45) - 1));
      chk("rst_mid_no_done", 128'(b), 128'(0));
      run_frame(vecs[0], "post_rst_token");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
